fp_multiplier_param: RTL and testbench

Parametrised IEEE-754 floating-point multiplier with a start/done handshake. It is the successor to the fixed single-precision multi-cycle multiplier. Generalisations:
- exponent and mantissa widths set by parameters
- four run-time rounding modes
- full subnormal input/output handling
- correct special-value handling
- inexact flag

It sits in the arithmetic datapath as a multi-cycle, non-pipelined unit: one operation in flight at a time.

---
 rtl/fp_multiplier_param.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-754 multiplier with parametrised field widths, four rounding
// modes, subnormal support and a start/done handshake; one operation in flight.
module fp_multiplier_param #(
  parameter int EXP_W          = 8,
  parameter int MAN_W          = 23,
  parameter bit CANON_NAN_SIGN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           rnd_mode_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 nan_o,
  output logic                 infinit_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 inexact_o
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = EXP_W + 3;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int LZW = $clog2(MAN_W + 2);
  localparam int SHW = $clog2(MAN_W + 4);

  typedef logic signed [XW-1:0] sexp_t;
  typedef enum logic [1:0] {RNE, RTZ, RUP, RDN} rnd_t;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

  localparam sexp_t            BIAS     = sexp_t'((1 << (EXP_W - 1)) - 1);
  localparam sexp_t            EXP_TOP  = sexp_t'((1 << EXP_W) - 1);
  localparam sexp_t            SH_MAX   = sexp_t'(MAN_W + 3);
  localparam sexp_t            ONE      = sexp_t'(1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]     QNAN     = {CANON_NAN_SIGN, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [MAN_W:0] m);
    logic [LZW-1:0] n;
    n = LZW'(MAN_W + 1);
    for (int i = 0; i <= MAN_W; i++)
      if (m[i]) n = LZW'(MAN_W - i);
    return n;
  endfunction

  // Subnormals are shifted up so the hidden-bit position is always set,
  // which keeps the product's leading one in one of two known positions.
  function automatic void prenorm(input  logic [EXP_W-1:0] e,
                                  input  logic [MAN_W-1:0] f,
                                  output logic [MAN_W:0]   man,
                                  output sexp_t            ex);
    logic [LZW-1:0] lz;
    lz = lzc({1'b0, f});
    if (e == '0) begin
      man = {1'b0, f} << lz;
      ex  = ONE - BIAS - sexp_t'(lz);
    end else begin
      man = {1'b1, f};
      ex  = sexp_t'(e) - BIAS;
    end
  endfunction

  state_t state, state_next;

  logic [W-1:0]     a_q, b_q;
  rnd_t             rnd_q;
  logic             sign_q, byp_q, byp_nan_q, byp_inf_q;
  logic [W-1:0]     byp_val_q;
  logic [MAN_W:0]   man_a_q, man_b_q;
  sexp_t            exp_a_q, exp_b_q;
  logic [PW-1:0]    prod_q;
  sexp_t            prod_exp_q;
  logic [PW-2:0]    norm_man_q;
  logic             norm_sticky_q;
  sexp_t            norm_exp_q;
  logic [W-1:0]     product_q;
  logic             nan_q, inf_q, ovf_q, unf_q, inx_q;

  // ---------------- FSM ----------------
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_i) state_next = S_UNPACK;
      S_UNPACK: state_next = S_MULT;
      S_MULT:   state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    done_o = (state == S_DONE);
    busy_o = (state != S_IDLE);
  end

  // ---------------- UNPACK ----------------
  logic             sign_a, sign_b, sign_r;
  logic [EXP_W-1:0] efld_a, efld_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [MAN_W:0]   man_a, man_b;
  sexp_t            exp_a, exp_b;
  logic             byp, byp_nan, byp_inf;
  logic [W-1:0]     byp_val;

  assign {sign_a, efld_a, frac_a} = a_q;
  assign {sign_b, efld_b, frac_b} = b_q;
  assign sign_r = sign_a ^ sign_b;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    nan_a  = (efld_a == EXP_ONES) && (frac_a != '0);
    nan_b  = (efld_b == EXP_ONES) && (frac_b != '0);
    inf_a  = (efld_a == EXP_ONES) && (frac_a == '0);
    inf_b  = (efld_b == EXP_ONES) && (frac_b == '0);
    zero_a = (efld_a == '0) && (frac_a == '0);
    zero_b = (efld_b == '0) && (frac_b == '0);
    prenorm(efld_a, frac_a, man_a, exp_a);
    prenorm(efld_b, frac_b, man_b, exp_b);
    byp     = 1'b1;
    byp_nan = 1'b0;
    byp_inf = 1'b0;
    byp_val = '0;
    if (nan_a || nan_b) begin
      byp_val = QNAN;
      byp_nan = 1'b1;
    end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
      byp_val = QNAN;
      byp_nan = 1'b1;
      byp_inf = 1'b1;
    end else if (inf_a || inf_b) begin
      byp_val = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      byp_inf = 1'b1;
    end else if (zero_a || zero_b) begin
      byp_val = {sign_r, {(W-1){1'b0}}};
    end else begin
      byp = 1'b0;
    end
  end

  // ---------------- MULT ----------------
  logic [PW-1:0] prod;
  sexp_t         prod_exp;

  assign prod     = PW'(man_a_q) * PW'(man_b_q);
  assign prod_exp = exp_a_q + exp_b_q + BIAS;

  // ---------------- NORM ----------------
  logic [PW-1:0]  pn, pmask;
  logic           sticky_n;
  sexp_t          exp_n, shift_amt;
  logic [SHW-1:0] sh;

  always_comb begin
    pn        = prod_q;
    exp_n     = prod_exp_q;
    sticky_n  = 1'b0;
    shift_amt = '0;
    sh        = '0;
    pmask     = '0;
    if (prod_q[PW-1]) begin
      pn       = prod_q >> 1;
      exp_n    = prod_exp_q + ONE;
      sticky_n = prod_q[0];
    end
    // Tiny result: denormalise so the fraction lines up with exponent field 0.
    if (exp_n < ONE) begin
      shift_amt = ONE - exp_n;
      sh        = (shift_amt > SH_MAX) ? SHW'(SH_MAX) : SHW'(shift_amt);
      pmask     = (PW'(1) << sh) - PW'(1);
      sticky_n  = sticky_n | (|(pn & pmask));
      pn        = pn >> sh;
      exp_n     = '0;
    end
  end

  // ---------------- ROUND ----------------
  logic [PW-1:0]    ext;
  logic [MAN_W:0]   man_r;
  logic             g, r, s, inc, carry;
  logic [MAN_W+1:0] rounded;
  sexp_t            exp_r;
  logic [MAN_W-1:0] frac_r;
  logic             ovf_r, unf_r, inx_r;
  logic [W-1:0]     res_r, max_fin, inf_val;

  always_comb begin
    ext     = {norm_man_q, norm_sticky_q};
    man_r   = ext[PW-1:MAN_W+1];
    g       = ext[MAN_W];
    r       = ext[MAN_W-1];
    s       = |ext[MAN_W-2:0];
    inx_r   = g | r | s;
    inc     = 1'b0;
    case (rnd_q)
      RNE: inc = g & (r | s | man_r[0]);
      RTZ: inc = 1'b0;
      RUP: inc = inx_r & ~sign_q;
      RDN: inc = inx_r & sign_q;
    endcase
    rounded = {1'b0, man_r} + (MAN_W+2)'(inc);
    carry   = rounded[MAN_W+1];
    // A subnormal that rounds into the hidden bit becomes the minimum normal.
    if (norm_exp_q == '0) exp_r = sexp_t'(rounded[MAN_W]);
    else                  exp_r = norm_exp_q + sexp_t'(carry);
    frac_r  = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    ovf_r   = (exp_r >= EXP_TOP);
    unf_r   = !ovf_r && (exp_r == '0) && inx_r;
    max_fin = {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
    inf_val = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
    res_r   = {sign_q, exp_r[EXP_W-1:0], frac_r};
    if (ovf_r) begin
      inx_r = 1'b1;
      case (rnd_q)
        RNE: res_r = inf_val;
        RTZ: res_r = max_fin;
        RUP: res_r = sign_q ? max_fin : inf_val;
        RDN: res_r = sign_q ? inf_val : max_fin;
      endcase
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      rnd_q         <= RNE;
      sign_q        <= 1'b0;
      byp_q         <= 1'b0;
      byp_nan_q     <= 1'b0;
      byp_inf_q     <= 1'b0;
      byp_val_q     <= '0;
      man_a_q       <= '0;
      man_b_q       <= '0;
      exp_a_q       <= '0;
      exp_b_q       <= '0;
      prod_q        <= '0;
      prod_exp_q    <= '0;
      norm_man_q    <= '0;
      norm_sticky_q <= 1'b0;
      norm_exp_q    <= '0;
      product_q     <= '0;
      nan_q         <= 1'b0;
      inf_q         <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      inx_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          rnd_q <= rnd_t'(rnd_mode_i);
        end
        S_UNPACK: begin
          sign_q    <= sign_r;
          byp_q     <= byp;
          byp_nan_q <= byp_nan;
          byp_inf_q <= byp_inf;
          byp_val_q <= byp_val;
          man_a_q   <= man_a;
          man_b_q   <= man_b;
          exp_a_q   <= exp_a;
          exp_b_q   <= exp_b;
        end
        S_MULT: begin
          prod_q     <= prod;
          prod_exp_q <= prod_exp;
        end
        S_NORM: begin
          norm_man_q    <= pn[PW-2:0];
          norm_sticky_q <= sticky_n;
          norm_exp_q    <= exp_n;
        end
        S_ROUND: begin
          if (byp_q) begin
            product_q <= byp_val_q;
            nan_q     <= byp_nan_q;
            inf_q     <= byp_inf_q;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
          end else begin
            product_q <= res_r;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= ovf_r;
            unf_q     <= unf_r;
            inx_q     <= inx_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign product_o   = product_q;
  assign nan_o       = nan_q;
  assign infinit_o   = inf_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Scoreboard bench for fp_multiplier_param: single-precision and half-precision
// instances, directed vectors with hand-computed results and flags.
module tb_fp_multiplier_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // single precision instance
  logic        start, done, busy, nan, inf, ovf, unf, inx;
  logic [1:0]  mode;
  logic [31:0] a, b, product;

  fp_multiplier_param u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .rnd_mode_i(mode),
    .a_i(a), .b_i(b), .product_o(product), .done_o(done), .busy_o(busy),
    .nan_o(nan), .infinit_o(inf), .overflow_o(ovf), .underflow_o(unf),
    .inexact_o(inx)
  );

  // half precision instance
  logic        h_start, h_done, h_busy, h_nan, h_inf, h_ovf, h_unf, h_inx;
  logic [1:0]  h_mode;
  logic [15:0] h_a, h_b, h_product;

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk(clk), .rst_n(rst_n), .start_i(h_start), .rnd_mode_i(h_mode),
    .a_i(h_a), .b_i(h_b), .product_o(h_product), .done_o(h_done), .busy_o(h_busy),
    .nan_o(h_nan), .infinit_o(h_inf), .overflow_o(h_ovf), .underflow_o(h_unf),
    .inexact_o(h_inx)
  );

  typedef struct {
    logic [31:0] p;
    logic [4:0]  f;     // {nan, inf, overflow, underflow, inexact}
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t hsb[$];
  exp_t mon_e, hmon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] M_RNE = 2'b00, M_RTZ = 2'b01, M_RUP = 2'b10, M_RDN = 2'b11;

  logic [31:0] bx [3] = '{32'h3FC00000, 32'h3F800001, 32'h80000000};
  logic [31:0] by [3] = '{32'h40000000, 32'h3F800001, 32'h40000000};
  logic [31:0] bp [3] = '{32'h40400000, 32'h3F800002, 32'h80000000};
  logic [4:0]  bf [3] = '{5'b00000, 5'b00001, 5'b00000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [4:0] f, input string name);
    exp_t e;
    e.p = p; e.f = f; e.name = name;
    sb.push_back(e);
  endtask

  // Monitors: pop the oldest expectation whenever a result is presented.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 64'(done), 64'(0));
      else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_product"}, 64'(product), 64'(mon_e.p));
        check({mon_e.name, "_flags"}, 64'({nan, inf, ovf, unf, inx}), 64'(mon_e.f));
      end
    end
  end

  always @(negedge clk) begin
    if (h_done) begin
      if (hsb.size() == 0) check("half_unexpected_done", 64'(h_done), 64'(0));
      else begin
        hmon_e = hsb.pop_front();
        check({hmon_e.name, "_product"}, 64'(h_product), 64'(hmon_e.p));
        check({hmon_e.name, "_flags"}, 64'({h_nan, h_inf, h_ovf, h_unf, h_inx}), 64'(hmon_e.f));
      end
    end
  end

  // Issue one operation from IDLE and verify latency and busy coverage.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m,
                        input logic [31:0] p, input logic [4:0] f, input string name);
    int   cyc;
    logic busy_bad;
    @(negedge clk);
    a = x; b = y; mode = m; start = 1'b1;
    push(p, f, name);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0; busy_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_bad = 1'b1;
    end while (!done && cyc < 20);
    check({name, "_latency"}, 64'(cyc), 64'(5));
    check({name, "_busy"}, 64'(busy_bad), 64'(0));
  endtask

  task automatic run_half(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m,
                          input logic [15:0] p, input logic [4:0] f, input string name);
    int   cyc;
    exp_t e;
    @(negedge clk);
    h_a = x; h_b = y; h_mode = m; h_start = 1'b1;
    e.p = 32'(p); e.f = f; e.name = name;
    hsb.push_back(e);
    @(posedge clk);
    #1;
    h_start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!h_done && cyc < 20);
    check({name, "_latency"}, 64'(cyc), 64'(5));
  endtask

  initial begin
    int nd, cyc;
    start = 1'b0; mode = M_RNE; a = '0; b = '0;
    h_start = 1'b0; h_mode = M_RNE; h_a = '0; h_b = '0;
    repeat (3) @(negedge clk);
    check("rst_product", 64'(product), 64'(0));
    check("rst_flags", 64'({nan, inf, ovf, unf, inx}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;

    run_op(32'h3FC00000, 32'h40000000, M_RNE, 32'h40400000, 5'b00000, "basic");
    run_op(32'h3F800001, 32'h3F800001, M_RNE, 32'h3F800002, 5'b00001, "rne");
    run_op(32'h3F800001, 32'h3F800001, M_RUP, 32'h3F800003, 5'b00001, "rup");
    run_op(32'h3F800001, 32'h3F800001, M_RTZ, 32'h3F800002, 5'b00001, "rtz");
    run_op(32'h3F800001, 32'h3F800001, M_RDN, 32'h3F800002, 5'b00001, "rdn_pos");
    run_op(32'hBF800001, 32'h3F800001, M_RDN, 32'hBF800003, 5'b00001, "rdn_neg");
    run_op(32'h7F7FFFFF, 32'h40000000, M_RNE, 32'h7F800000, 5'b00101, "ovf_rne");
    run_op(32'h7F7FFFFF, 32'h40000000, M_RTZ, 32'h7F7FFFFF, 5'b00101, "ovf_rtz");
    run_op(32'hFF7FFFFF, 32'h40000000, M_RUP, 32'hFF7FFFFF, 5'b00101, "ovf_rup_neg");
    run_op(32'hFF7FFFFF, 32'h40000000, M_RDN, 32'hFF800000, 5'b00101, "ovf_rdn_neg");
    run_op(32'h00800000, 32'h3F000000, M_RNE, 32'h00400000, 5'b00000, "sub_exact");
    run_op(32'h00000001, 32'h3F000000, M_RNE, 32'h00000000, 5'b00011, "unf_rne");
    run_op(32'h00000001, 32'h3F000000, M_RUP, 32'h00000001, 5'b00011, "unf_rup");
    run_op(32'h7F800000, 32'h00000000, M_RNE, 32'h7FC00000, 5'b11000, "inf_x_zero");
    run_op(32'hFF800000, 32'h40000000, M_RNE, 32'hFF800000, 5'b01000, "neg_inf");
    run_op(32'h7FC00001, 32'h3F800000, M_RNE, 32'h7FC00000, 5'b10000, "nan_in");
    run_op(32'h80000000, 32'h40000000, M_RNE, 32'h80000000, 5'b00000, "neg_zero");
    run_op(32'h007FFFFF, 32'h3F800001, M_RNE, 32'h00800000, 5'b00001, "sub_to_norm");

    // Abort during NORM: outputs clear and no result appears.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; mode = M_RNE; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_product", 64'(product), 64'(0));
    check("abort_flags", 64'({nan, inf, ovf, unf, inx}), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle", 64'(busy), 64'(0));
    run_op(32'h3FC00000, 32'h40000000, M_RNE, 32'h40400000, 5'b00000, "post_reset");

    // start held high: a result every 6 cycles, operand churn while busy ignored.
    @(negedge clk);
    a = bx[0]; b = by[0]; mode = M_RNE; start = 1'b1;
    push(bp[0], bf[0], "b2b_0");
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check($sformatf("b2b_%0d_time", nd), 64'(cyc), 64'(5 + 6 * nd));
        nd++;
        if (nd < 3) begin
          a = bx[nd]; b = by[nd];
          push(bp[nd], bf[nd], $sformatf("b2b_%0d", nd));
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        a = $urandom; b = $urandom;
      end
    end
    check("b2b_count", 64'(nd), 64'(3));

    run_half(16'h3C00, 16'h3C00, M_RNE, 16'h3C00, 5'b00000, "half_one");
    run_half(16'h7BFF, 16'h4000, M_RNE, 16'h7C00, 5'b00101, "half_ovf_rne");
    run_half(16'h7BFF, 16'h4000, M_RTZ, 16'h7BFF, 5'b00101, "half_ovf_rtz");
    run_half(16'h0001, 16'h3800, M_RUP, 16'h0001, 5'b00011, "half_unf_rup");

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("half_sb_empty", 64'(hsb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
